pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC controller for the fetch stage.
- Selects the next PC value from sequential, ID-stage jump and EX-stage branch/redirect sources.
- Generates the write/stall controls for the PC register and flushes for IF/ID.
- Captures redirects that arrive while the pipeline is stalled so they are never lost.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, PC value presented during BOOT.
- INST_BYTES, 4, sequential increment.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pc_i  in  ADDR_W  current PC from the PC register
- icache_stall_i  in  1  I-cache miss stall
- dcache_stall_i  in  1  D-cache miss stall
- hazard_i  in  1  load-use hazard from hazard unit; freezes PC
- id_redirect_i  in  1  ID-stage jump (JAL) taken
- id_target_i  in  ADDR_W  ID jump target
- ex_redirect_i  in  1  EX-stage branch taken / JALR
- ex_target_i  in  ADDR_W  EX target
- pc_next_o  out  ADDR_W  value to load into the PC register
- pc_write_o  out  1  PC write enable
- pc_stall_o  out  1  PC stall (= icache_stall_i | dcache_stall_i)
- flush_if_o  out  1  squash the IF/ID instruction
- flush_id_o  out  1  squash the ID/EX instruction
- boot_o  out  1  high while in BOOT

Behaviour:
- FSM states and transitions:
  - BOOT → RUN after exactly one cycle.
  - RUN → PEND when stall=1 and (ex_redirect_i | (id_redirect_i & ~hazard_i)).
  - PEND → RUN on the first cycle with stall=0.
- Reset (async, rst_n=0):
  - state=BOOT, pend_target=0, pend_ex=0.
  - Outputs: pc_next_o=RESET_PC, pc_write_o=0, flush_if_o=0, flush_id_o=0, boot_o=1.
- BOOT: pc_next_o=RESET_PC, pc_write_o=1 (the PC register loads RESET_PC), no flushes.
- RUN, stall=0, next-PC priority:
  - ex_redirect_i → ex_target_i, with flush_if_o=1 and flush_id_o=1; this overrides hazard_i, because the hazarding instruction is squashed.
  - else id_redirect_i & ~hazard_i → id_target_i, with flush_if_o=1.
  - else hazard_i → pc_write_o=0, pc_next_o=pc_i.
  - else pc_i + INST_BYTES.
  - pc_write_o=1 in all cases except hazard.
- RUN, stall=1:
  - pc_write_o=1, but the PC register does not update because pc_stall_o=1.
  - Flushes are 0.
  - Any valid redirect (same priority as above) is latched into pend_target, with pend_ex = source was EX; go to PEND.
- PEND, stall=1:
  - A new ex_redirect_i overwrites pend_target and sets pend_ex=1.
  - id_redirect_i is ignored.
  - Stay in PEND.
- PEND, stall=0:
  - pc_next_o=pend_target, pc_write_o=1, flush_if_o=1, flush_id_o=pend_ex.
  - Same-cycle ex_redirect_i takes precedence over pend_target.
  - Go to RUN.
- Latency: redirect to PC register update is 1 clock when not stalled; stall cycles are added when stalled.
- Targets: bits [1:0] are forced to 0 before use.
- pc_i + INST_BYTES wraps modulo 2^ADDR_W (FFFF_FFFC → 0000_0000).
- Flushes are combinational, asserted only in the cycle the redirect is actually applied (pc_write_o & ~pc_stall_o).
- Reset mid-PEND drops the pending redirect and returns to BOOT.

Optional Feature:
- Macro: PCSEQ_PERF_EN.
- When defined, adds outputs perf_stall_cnt_o[31:0] and perf_redirect_cnt_o[31:0]:
  - Stall counter counts cycles with pc_stall_o=1.
  - Redirect counter counts applied redirects.
  - Both saturate at FFFF_FFFF and reset to 0.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package pcseq_pkg holds:
  - state encoding (BOOT=2'd0, RUN=2'd1, PEND=2'd2);
  - INST_BYTES;
  - the RESET_PC default.
- One sub-module, pcseq_next_mux: the combinational priority select and target alignment. The FSM and pending registers stay in the top.

Test Plan:
- Reset release with RESET_PC=0 → BOOT for 1 cycle with pc_next_o=0 and pc_write_o=1; then sequential 0,4,8 on pc_next_o.
- pc_i=0x100, id_redirect_i=1, id_target_i=0x203 → pc_next_o=0x200, flush_if_o=1, flush_id_o=0.
- pc_i=0x100, hazard_i=1 with ex_redirect_i=1, ex_target_i=0x400 → pc_next_o=0x400, pc_write_o=1, both flushes=1.
- Stall asserted for 3 cycles; EX redirect to 0x800 in stall cycle 1 → no flushes during stall; first unstalled cycle gives pc_next_o=0x800, flush_if_o=1, flush_id_o=1.
- pc_i=0xFFFF_FFFC with no events → pc_next_o=0x0000_0000.
- rst_n pulsed low while in PEND → outputs return to reset values immediately; after release, no flush and the PC restarts at RESET_PC.

Source files
------------

// File: rtl/pcseq_pkg.sv
// Shared definitions for the next-PC sequencer: FSM encoding and default constants.
package pcseq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pcseq_state_e;

  localparam int          PCSEQ_ADDR_W     = 32;
  localparam logic [31:0] PCSEQ_RESET_PC   = 32'h0000_0000;
  localparam int          PCSEQ_INST_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus between the pipeline (master) and the next-PC sequencer (slave).
interface pc_sequencer_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] pc_i;
  logic              icache_stall_i;
  logic              dcache_stall_i;
  logic              hazard_i;
  logic              id_redirect_i;
  logic [ADDR_W-1:0] id_target_i;
  logic              ex_redirect_i;
  logic [ADDR_W-1:0] ex_target_i;
  logic [ADDR_W-1:0] pc_next_o;
  logic              pc_write_o;
  logic              pc_stall_o;
  logic              flush_if_o;
  logic              flush_id_o;
  logic              boot_o;

  modport master (
    output pc_i, icache_stall_i, dcache_stall_i, hazard_i,
           id_redirect_i, id_target_i, ex_redirect_i, ex_target_i,
    input  pc_next_o, pc_write_o, pc_stall_o, flush_if_o, flush_id_o, boot_o
  );

  modport slave (
    input  pc_i, icache_stall_i, dcache_stall_i, hazard_i,
           id_redirect_i, id_target_i, ex_redirect_i, ex_target_i,
    output pc_next_o, pc_write_o, pc_stall_o, flush_if_o, flush_id_o, boot_o
  );
endinterface

// File: rtl/pcseq_next_mux.sv
// Next-PC priority select with target alignment; flushes here are raw (not yet gated by stall).
module pcseq_next_mux
  import pcseq_pkg::*;
#(
  parameter int ADDR_W     = PCSEQ_ADDR_W,
  parameter int INST_BYTES = PCSEQ_INST_BYTES
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              hazard,
  input  logic              id_redirect,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              pend_vld,
  input  logic [ADDR_W-1:0] pend_target,
  input  logic              pend_ex,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              flush_if,
  output logic              flush_id,
  output logic [ADDR_W-1:0] ex_tgt_al,
  output logic [ADDR_W-1:0] id_tgt_al,
  output logic              id_take
);

  assign ex_tgt_al = {ex_target[ADDR_W-1:2], 2'b00};
  assign id_tgt_al = {id_target[ADDR_W-1:2], 2'b00};
  assign id_take   = id_redirect & ~hazard;

  // EX beats everything (it squashes the hazarding op); a pending redirect beats ID.
  always_comb begin
    pc_next  = pc + ADDR_W'(INST_BYTES);
    pc_write = 1'b1;
    flush_if = 1'b0;
    flush_id = 1'b0;
    if (ex_redirect) begin
      pc_next  = ex_tgt_al;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (pend_vld) begin
      pc_next  = pend_target;
      flush_if = 1'b1;
      flush_id = pend_ex;
    end else if (id_take) begin
      pc_next  = id_tgt_al;
      flush_if = 1'b1;
    end else if (hazard) begin
      pc_next  = pc;
      pc_write = 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/PEND FSM holding redirects that land during cache stalls.
// Optional PCSEQ_PERF_EN adds saturating stall and applied-redirect counters.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int                ADDR_W     = PCSEQ_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(PCSEQ_RESET_PC),
  parameter int                INST_BYTES = PCSEQ_INST_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_sequencer_if.slave    bus
`ifdef PCSEQ_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt_o,
  output logic [31:0]      perf_redirect_cnt_o
`endif
);

  pcseq_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_ex_q, pend_ex_d;

  logic              stall;
  logic [ADDR_W-1:0] mux_next, ex_al, id_al;
  logic              mux_wr, mux_fi, mux_fid, id_take;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_write, flush_if, flush_id, boot;

  assign stall = bus.icache_stall_i | bus.dcache_stall_i;

  pcseq_next_mux #(.ADDR_W(ADDR_W), .INST_BYTES(INST_BYTES)) u_next_mux (
    .pc          (bus.pc_i),
    .hazard      (bus.hazard_i),
    .id_redirect (bus.id_redirect_i),
    .id_target   (bus.id_target_i),
    .ex_redirect (bus.ex_redirect_i),
    .ex_target   (bus.ex_target_i),
    .pend_vld    (state_q == ST_PEND),
    .pend_target (pend_tgt_q),
    .pend_ex     (pend_ex_q),
    .pc_next     (mux_next),
    .pc_write    (mux_wr),
    .flush_if    (mux_fi),
    .flush_id    (mux_fid),
    .ex_tgt_al   (ex_al),
    .id_tgt_al   (id_al),
    .id_take     (id_take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pend_tgt_q <= '0;
      pend_ex_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      pend_ex_q  <= pend_ex_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    pend_ex_d  = pend_ex_q;
    pc_next    = mux_next;
    // While stalled the write is requested but the PC register holds on pc_stall.
    pc_write   = stall ? 1'b1 : mux_wr;
    flush_if   = mux_fi & ~stall;
    flush_id   = mux_fid & ~stall;
    boot       = 1'b0;
    case (state_q)
      ST_BOOT: begin
        pc_next  = RESET_PC;
        pc_write = rst_n;
        flush_if = 1'b0;
        flush_id = 1'b0;
        boot     = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (stall && (bus.ex_redirect_i || id_take)) begin
          state_d    = ST_PEND;
          pend_tgt_d = bus.ex_redirect_i ? ex_al : id_al;
          pend_ex_d  = bus.ex_redirect_i;
        end
      end
      ST_PEND: begin
        if (!stall) begin
          state_d = ST_RUN;
        end else if (bus.ex_redirect_i) begin
          pend_tgt_d = ex_al;
          pend_ex_d  = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign bus.pc_next_o  = pc_next;
  assign bus.pc_write_o = pc_write;
  assign bus.pc_stall_o = stall;
  assign bus.flush_if_o = flush_if;
  assign bus.flush_id_o = flush_id;
  assign bus.boot_o     = boot;

`ifdef PCSEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o    <= '0;
      perf_redirect_cnt_o <= '0;
    end else begin
      if (stall && perf_stall_cnt_o != 32'hFFFF_FFFF)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      // Every applied redirect squashes IF/ID, so flush_if marks it exactly.
      if (flush_if && perf_redirect_cnt_o != 32'hFFFF_FFFF)
        perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule
